// File: rtl/nts_dispatcher_buffer.sv
// Single-frame RX buffer between MAC RX and nts_engine dispatch port.
// Optional frame counters: define NTS_DISPATCHER_COUNTERS_EN.
module nts_dispatcher_buffer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic [7:0]  i_rx_data_valid,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_good_frame,
  input  logic        i_rx_bad_frame,
  output logic        o_dispatch_packet_available,
  input  logic        i_dispatch_packet_read_discard,
  output logic [7:0]  o_dispatch_data_valid,
  output logic        o_dispatch_fifo_empty,
  input  logic        i_dispatch_fifo_rd_en,
  output logic [63:0] o_dispatch_fifo_rd_data
`ifdef NTS_DISPATCHER_COUNTERS_EN
  ,
  output logic [31:0] o_cnt_good,
  output logic [31:0] o_cnt_bad,
  output logic [31:0] o_cnt_dropped
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WRITE,
    S_AVAILABLE,
    S_DROP
  } state_t;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  state_t state;
  state_t state_d;
  ptr_t   wr_ptr;
  ptr_t   wr_ptr_d;
  ptr_t   rd_ptr;
  ptr_t   rd_ptr_d;
  logic   skip;
  logic   skip_d;
  logic   mem_we;
  logic   rd_fire;
  logic   pulse;
  logic   word;

  logic [71:0] mem [DEPTH];

  assign pulse = i_rx_good_frame | i_rx_bad_frame;
  assign word  = (|i_rx_data_valid) & ~pulse;

  assign o_dispatch_packet_available = (state == S_AVAILABLE);
  assign o_dispatch_fifo_empty =
    (state != S_AVAILABLE) | (rd_ptr == wr_ptr);

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    skip_d   = skip;
    mem_we   = 1'b0;
    rd_fire  = 1'b0;
    unique case (state)
      S_EMPTY: begin
        // skip covers the tail of a frame that began while busy
        if (skip) begin
          if (pulse) skip_d = 1'b0;
        end else if (word) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr + ptr_t'(1);
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_rx_bad_frame) begin
          wr_ptr_d = '0;
          state_d  = S_EMPTY;
        end else if (i_rx_good_frame) begin
          if (wr_ptr != '0) begin
            rd_ptr_d = '0;
            state_d  = S_AVAILABLE;
          end
        end else if (word) begin
          if (wr_ptr == ptr_t'(DEPTH)) begin
            wr_ptr_d = '0;
            state_d  = S_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr + ptr_t'(1);
          end
        end
      end
      S_DROP: begin
        if (pulse) state_d = S_EMPTY;
      end
      S_AVAILABLE: begin
        if (skip) begin
          if (pulse) skip_d = 1'b0;
        end else if (word) begin
          skip_d = 1'b1;
        end
        if (i_dispatch_packet_read_discard) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = S_EMPTY;
        end else if (i_dispatch_fifo_rd_en &&
                     !o_dispatch_fifo_empty) begin
          rd_fire  = 1'b1;
          rd_ptr_d = rd_ptr + ptr_t'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state                   <= S_EMPTY;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      skip                    <= 1'b0;
      o_dispatch_data_valid   <= '0;
      o_dispatch_fifo_rd_data <= '0;
    end else begin
      state  <= state_d;
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      skip   <= skip_d;
      if (rd_fire) begin
        {o_dispatch_data_valid, o_dispatch_fifo_rd_data} <=
          mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {i_rx_data_valid, i_rx_data};
    end
  end

`ifdef NTS_DISPATCHER_COUNTERS_EN
  logic good_inc;
  logic bad_inc;
  logic drop_inc;

  assign good_inc = (state == S_WRITE) & (state_d == S_AVAILABLE);
  assign bad_inc  = (state == S_WRITE) & i_rx_bad_frame;
  assign drop_inc = ((state == S_WRITE) & (state_d == S_DROP)) |
                    ((state == S_AVAILABLE) & ~skip & skip_d);

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_cnt_good    <= '0;
      o_cnt_bad     <= '0;
      o_cnt_dropped <= '0;
    end else begin
      if (good_inc && !(&o_cnt_good))
        o_cnt_good <= o_cnt_good + 32'd1;
      if (bad_inc && !(&o_cnt_bad))
        o_cnt_bad <= o_cnt_bad + 32'd1;
      if (drop_inc && !(&o_cnt_dropped))
        o_cnt_dropped <= o_cnt_dropped + 32'd1;
    end
  end
`endif

endmodule
